// File: rtl/btn_debounce_pkg.sv
// ============================================================================
// btn_debounce_pkg : state encoding and timing helpers for btn_debounce_pulser
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_debounce_pkg;

  localparam logic [2:0] INI  = 3'b000;
  localparam logic [2:0] WQ   = 3'b001;
  localparam logic [2:0] SCEN = 3'b010;
  localparam logic [2:0] WH   = 3'b011;
  localparam logic [2:0] MCEN = 3'b100;
  localparam logic [2:0] WFCR = 3'b101;

  typedef enum logic [2:0] {
    ST_INI  = INI,
    ST_WQ   = WQ,
    ST_SCEN = SCEN,
    ST_WH   = WH,
    ST_MCEN = MCEN,
    ST_WFCR = WFCR
  } state_e;

  // Debounce window in clocks
  function automatic int unsigned t_db(input int unsigned n_dc);
    return 32'd1 << (n_dc - 32'd2);
  endfunction

  // Auto-repeat period in clocks
  function automatic int unsigned t_rp(input int unsigned n_dc);
    return 32'd1 << (n_dc - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_sync2.sv
// ============================================================================
// btn_sync2 : two-flop synchronizer with asynchronous active-high reset
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_sync2 (
  input  logic board_clk,
  input  logic Reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

`default_nettype wire

// File: rtl/btn_debounce_pulser.sv
// ============================================================================
// btn_debounce_pulser : push-button debouncer producing DPB/SCEN/MCEN/CCEN
// Optional input synchronizer: define BTN_DEBOUNCE_SYNC_EN
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_pulser
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_DC = 25
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic       CCEN,
  output logic [2:0] state
);

  localparam logic [N_DC-1:0] DB_LAST = N_DC'(t_db(N_DC) - 32'd1);
  localparam logic [N_DC-1:0] RP_LAST = N_DC'(t_rp(N_DC) - 32'd1);

  logic            pb_i;
  state_e          state_q, state_d;
  logic [N_DC-1:0] cnt_q;
  logic            cnt_run;

`ifdef BTN_DEBOUNCE_SYNC_EN
  btn_sync2 u_sync (
    .board_clk (board_clk),
    .Reset     (Reset),
    .d_i       (PB),
    .q_o       (pb_i)
  );
`else
  assign pb_i = PB;
`endif

  // Release wins over the repeat terminal count in WH
  always_comb begin
    state_d = ST_INI;
    case (state_q)
      ST_INI:  if (pb_i) state_d = ST_WQ;
               else      state_d = ST_INI;
      ST_WQ:   if (!pb_i)                state_d = ST_INI;
               else if (cnt_q == DB_LAST) state_d = ST_SCEN;
               else                       state_d = ST_WQ;
      ST_SCEN: state_d = ST_WH;
      ST_WH:   if (!pb_i)                state_d = ST_WFCR;
               else if (cnt_q == RP_LAST) state_d = ST_MCEN;
               else                       state_d = ST_WH;
      ST_MCEN: state_d = ST_WH;
      ST_WFCR: if (pb_i)                 state_d = ST_WH;
               else if (cnt_q == DB_LAST) state_d = ST_INI;
               else                       state_d = ST_WFCR;
      default: state_d = ST_INI;
    endcase
  end

  assign cnt_run = (state_q == ST_WQ) || (state_q == ST_WH) || (state_q == ST_WFCR);

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_INI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || !cnt_run) cnt_q <= '0;
      else                                cnt_q <= cnt_q + N_DC'(1);
    end
  end

  always_comb begin
    DPB  = 1'b0;
    SCEN = 1'b0;
    MCEN = 1'b0;
    CCEN = 1'b0;
    case (state_q)
      ST_SCEN: begin DPB = 1'b1; SCEN = 1'b1; MCEN = 1'b1; CCEN = 1'b1; end
      ST_WH:   begin DPB = 1'b1; CCEN = 1'b1; end
      ST_MCEN: begin DPB = 1'b1; MCEN = 1'b1; CCEN = 1'b1; end
      ST_WFCR: DPB = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

`default_nettype wire
